// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz timing constants and helpers for the sync window boundaries.
package vga_timing_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int CNT_W_DEF     = 10;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // Sync is active on the half-open range [sync_start, sync_end).
    function automatic int sync_start(input int visible, input int front);
        return visible + front;
    endfunction

    function automatic int sync_end(input int visible, input int front, input int sync);
        return visible + front + sync;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: sync levels, visible flag, position and line/frame strobes.
interface vga_timing_gen_if import vga_timing_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF
);
    logic             hsync;
    logic             vsync;
    logic             display_on;
    logic [CNT_W-1:0] hpos;
    logic [CNT_W-1:0] vpos;
    logic             line_start;
    logic             frame_start;

    modport master (
        output hsync, vsync, display_on, hpos, vpos, line_start, frame_start
    );

    modport slave (
        input hsync, vsync, display_on, hpos, vpos, line_start, frame_start
    );
endinterface

// File: rtl/vga_wrap_counter.sv
// Modulo-MOD counter with enable; resets to MOD-1 so the first enabled step lands on 0.
module vga_wrap_counter #(
    parameter int MOD = 800,
    parameter int W   = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         wrap
);
    localparam logic [W-1:0] LAST = W'(MOD - 1);

    // count_next is exported so the parent can decode the upcoming position.
    always_comb begin
        wrap       = en && (count == LAST);
        count_next = count;
        if (en) begin
            count_next = (count == LAST) ? '0 : count + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= LAST;
        end else begin
            count <= count_next;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: chained h/v counters with registered sync/visible decode
// and line/frame strobes, all aligned to the same pixel.
module vga_timing_gen import vga_timing_pkg::*; #(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter bit SYNC_POL  = 1'b0,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(sync_start(H_VISIBLE, H_FRONT));
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(sync_end(H_VISIBLE, H_FRONT, H_SYNC));
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(sync_start(V_VISIBLE, V_FRONT));
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(sync_end(V_VISIBLE, V_FRONT, V_SYNC));

    logic [CNT_W-1:0] h_count, h_next, v_count, v_next;
    logic             h_wrap, v_wrap;
    logic             h_act, v_act, vis_next;
    logic             hsync_q, vsync_q, display_on_q, line_start_q, frame_start_q;

    vga_wrap_counter #(.MOD(H_TOTAL), .W(CNT_W)) u_hcnt (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .count      (h_count),
        .count_next (h_next),
        .wrap       (h_wrap)
    );

    vga_wrap_counter #(.MOD(V_TOTAL), .W(CNT_W)) u_vcnt (
        .clk        (clk),
        .reset      (reset),
        .en         (h_wrap),
        .count      (v_count),
        .count_next (v_next),
        .wrap       (v_wrap)
    );

    // Decoding the next position keeps the registered flags aligned with hpos/vpos.
    always_comb begin
        h_act    = (h_next >= HS_START) && (h_next < HS_END);
        v_act    = (v_next >= VS_START) && (v_next < VS_END);
        vis_next = (h_next < H_VIS_C) && (v_next < V_VIS_C);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            display_on_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= h_act ? SYNC_POL : ~SYNC_POL;
            vsync_q       <= v_act ? SYNC_POL : ~SYNC_POL;
            display_on_q  <= vis_next;
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.display_on  = display_on_q;
    assign vga.hpos        = h_count;
    assign vga.vpos        = v_count;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, positive-sync and reduced-timing instances checked
// every cycle against a position model, plus directed boundary measurements.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset;
    logic en;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CNT_W(10)) vif0 ();
    vga_timing_gen_if #(.CNT_W(10)) vif1 ();
    vga_timing_gen_if #(.CNT_W(6))  vif2 ();

    vga_timing_gen dut_std (.clk(clk), .reset(reset), .en(en), .vga(vif0));

    vga_timing_gen #(.SYNC_POL(1'b1)) dut_pos (.clk(clk), .reset(reset), .en(en), .vga(vif1));

    vga_timing_gen #(
        .H_VISIBLE(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .SYNC_POL(1'b0), .CNT_W(6)
    ) dut_small (.clk(clk), .reset(reset), .en(en), .vga(vif2));

    int p_hv[3]  = '{640, 640, 20};
    int p_hf[3]  = '{16, 16, 3};
    int p_hs[3]  = '{96, 96, 5};
    int p_hb[3]  = '{48, 48, 4};
    int p_vv[3]  = '{480, 480, 12};
    int p_vf[3]  = '{10, 10, 2};
    int p_vs[3]  = '{2, 2, 2};
    int p_vb[3]  = '{33, 33, 3};
    int p_pol[3] = '{0, 1, 0};

    int m_h[3], m_v[3], m_ls[3], m_fs[3];

    logic [31:0] o_h[3], o_v[3];
    logic        o_hs[3], o_vs[3], o_disp[3], o_ls[3], o_fs[3];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s dut%0d: observed %0d expected %0d", tag, d, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_sync(input int pos, input int vis, input int front,
                                             input int sync, input int pol);
        return ((pos >= vis + front) && (pos < vis + front + sync)) ? 32'(pol) : 32'(1 - pol);
    endfunction

    task automatic sample();
        o_h[0] = 32'(vif0.hpos); o_v[0] = 32'(vif0.vpos);
        o_hs[0] = vif0.hsync; o_vs[0] = vif0.vsync; o_disp[0] = vif0.display_on;
        o_ls[0] = vif0.line_start; o_fs[0] = vif0.frame_start;
        o_h[1] = 32'(vif1.hpos); o_v[1] = 32'(vif1.vpos);
        o_hs[1] = vif1.hsync; o_vs[1] = vif1.vsync; o_disp[1] = vif1.display_on;
        o_ls[1] = vif1.line_start; o_fs[1] = vif1.frame_start;
        o_h[2] = 32'(vif2.hpos); o_v[2] = 32'(vif2.vpos);
        o_hs[2] = vif2.hsync; o_vs[2] = vif2.vsync; o_disp[2] = vif2.display_on;
        o_ls[2] = vif2.line_start; o_fs[2] = vif2.frame_start;
    endtask

    task automatic check_all();
        sample();
        for (int d = 0; d < 3; d++) begin
            cmp("hpos", d, o_h[d], 32'(m_h[d]));
            cmp("vpos", d, o_v[d], 32'(m_v[d]));
            cmp("hsync", d, 32'(o_hs[d]), exp_sync(m_h[d], p_hv[d], p_hf[d], p_hs[d], p_pol[d]));
            cmp("vsync", d, 32'(o_vs[d]), exp_sync(m_v[d], p_vv[d], p_vf[d], p_vs[d], p_pol[d]));
            cmp("display_on", d, 32'(o_disp[d]),
                (m_h[d] < p_hv[d] && m_v[d] < p_vv[d]) ? 32'd1 : 32'd0);
            cmp("line_start", d, 32'(o_ls[d]), 32'(m_ls[d]));
            cmp("frame_start", d, 32'(o_fs[d]), 32'(m_fs[d]));
        end
    endtask

    // One clock: drive inputs, advance the position model, then check #1 after the edge.
    task automatic tick(input logic r, input logic e);
        int ht, vt;
        reset = r;
        en    = e;
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            ht = p_hv[d] + p_hf[d] + p_hs[d] + p_hb[d];
            vt = p_vv[d] + p_vf[d] + p_vs[d] + p_vb[d];
            if (!r) begin
                m_h[d] = ht - 1; m_v[d] = vt - 1; m_ls[d] = 0; m_fs[d] = 0;
            end else if (e) begin
                m_h[d] = m_h[d] + 1;
                if (m_h[d] == ht) begin
                    m_h[d] = 0;
                    m_v[d] = (m_v[d] + 1 == vt) ? 0 : m_v[d] + 1;
                end
                m_ls[d] = (m_h[d] == 0) ? 1 : 0;
                m_fs[d] = (m_h[d] == 0 && m_v[d] == 0) ? 1 : 0;
            end else begin
                m_ls[d] = 0; m_fs[d] = 0;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        int disp_fall, hs_fall, hs_rise, ls_next, ls_cnt, vt_target, period, vs_cnt, disp_cnt;
        reset = 1'b0;
        en    = 1'b0;

        // Reset held for three edges, then release with en=1.
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        cmp("reset_hpos", 0, o_h[0], 32'd799);
        cmp("reset_vpos", 0, o_v[0], 32'd524);
        tick(1'b1, 1'b1);
        cmp("first_frame_start", 0, 32'(o_fs[0]), 32'd1);
        cmp("first_display_on", 0, 32'(o_disp[0]), 32'd1);

        // Line 0 boundary measurements.
        disp_fall = -1; hs_fall = -1; hs_rise = -1; ls_next = -1;
        for (int k = 1; k <= 800; k++) begin
            tick(1'b1, 1'b1);
            if (disp_fall < 0 && o_disp[0] == 1'b0) disp_fall = k;
            if (hs_fall >= 0 && hs_rise < 0 && o_hs[0] == 1'b1) hs_rise = k;
            if (hs_fall < 0 && o_hs[0] == 1'b0) hs_fall = k;
            if (ls_next < 0 && o_ls[0] == 1'b1) ls_next = k;
        end
        cmp("display_fall_at", 0, 32'(disp_fall), 32'd640);
        cmp("hsync_fall_at", 0, 32'(hs_fall), 32'd656);
        cmp("hsync_rise_at", 0, 32'(hs_rise), 32'd752);
        cmp("line_period", 0, 32'(ls_next), 32'd800);
        cmp("line1_vpos", 0, o_v[0], 32'd1);

        // Random enable pattern.
        for (int k = 0; k < 3000; k++) tick(1'b1, $urandom_range(0, 3) != 0);

        // en 1,0,0,1 around the end of a line.
        for (int k = 0; k < 1000 && o_h[0] != 32'd798; k++) tick(1'b1, 1'b1);
        cmp("reach_798", 0, o_h[0], 32'd798);
        ls_cnt = 0;
        tick(1'b1, 1'b1); ls_cnt += int'(o_ls[0]);
        tick(1'b1, 1'b0); ls_cnt += int'(o_ls[0]);
        tick(1'b1, 1'b0); ls_cnt += int'(o_ls[0]);
        cmp("hold_hpos", 0, o_h[0], 32'd799);
        tick(1'b1, 1'b1); ls_cnt += int'(o_ls[0]);
        cmp("toggle_line_starts", 0, 32'(ls_cnt), 32'd1);

        // Full frame on the reduced-timing instance.
        for (int k = 0; k < 700 && o_fs[2] != 1'b1; k++) tick(1'b1, 1'b1);
        cmp("small_fs_found", 2, 32'(o_fs[2]), 32'd1);
        period = 0; vs_cnt = 0; disp_cnt = 0;
        for (int k = 0; k < 1300; k++) begin
            if (o_vs[2] == 1'b0) vs_cnt++;
            if (o_disp[2] == 1'b1) disp_cnt++;
            tick(1'b1, 1'b1);
            period++;
            if (o_fs[2] == 1'b1) break;
        end
        cmp("small_frame_period", 2, 32'(period), 32'd608);
        cmp("small_vsync_cycles", 2, 32'(vs_cnt), 32'd64);
        cmp("small_display_cycles", 2, 32'(disp_cnt), 32'd240);

        // Reset during active display, then recovery.
        vt_target = m_v[0] + 1;
        for (int k = 0; k < 3000 && !(o_h[0] == 32'd300 && o_v[0] == 32'(vt_target)); k++)
            tick(1'b1, 1'b1);
        cmp("reach_mid_h", 0, o_h[0], 32'd300);
        cmp("reach_mid_v", 0, o_v[0], 32'(vt_target));
        tick(1'b0, 1'b0);
        cmp("midreset_hpos", 0, o_h[0], 32'd799);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        cmp("recover_frame_start", 0, 32'(o_fs[0]), 32'd1);
        cmp("recover_vpos", 0, o_v[0], 32'd0);

        // Random enable with occasional resets.
        for (int k = 0; k < 2000; k++)
            tick($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
